// File: rtl/uart_mem_cmd_if.sv
// UART byte stream and memory port bundle used by the command sequencer.
// master: the sequencer; slave: the UART/memory environment side.
interface uart_mem_cmd_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_write_byte;
  logic [7:0] mem_read_byte;

  modport master (
    input  rx_valid,
    input  rx_byte,
    input  tx_busy,
    input  mem_read_byte,
    output tx_start,
    output tx_byte,
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_write_byte
  );

  modport slave (
    output rx_valid,
    output rx_byte,
    output tx_busy,
    output mem_read_byte,
    input  tx_start,
    input  tx_byte,
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_write_byte
  );
endinterface

// File: rtl/uart_mem_cmd.sv
// Command sequencer: parses CMD/ADDR/LEN[/data] frames from the UART receiver,
// performs byte-wise memory reads/writes and returns read data or a write ack.
module uart_mem_cmd #(
  parameter logic [7:0] ACK_BYTE = 8'h02
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_mem_cmd_if.master bus,
  output logic           o_busy,
  output logic           o_err
);

  localparam logic [7:0] CmdRead  = 8'h01;
  localparam logic [7:0] CmdWrite = 8'h02;

  typedef enum logic [3:0] {
    StIdle,
    StGetAddr,
    StGetLen,
    StGetData,
    StWr,
    StRdReq,
    StRdCap,
    StSend,
    StTxHold,
    StTxWait
  } state_e;

  state_e     r_state,     w_state_next;
  logic       r_is_write,  w_is_write_next;
  logic [8:0] r_count,     w_count_next;
  logic [7:0] r_addr,      w_addr_next;
  logic [7:0] r_wdata,     w_wdata_next;
  logic [7:0] r_tx_byte,   w_tx_byte_next;
  logic       r_err,       w_err_next;
  logic       r_tx_start;
  logic       r_mem_read;
  logic       r_mem_write;
  logic       r_busy;
  logic       w_rx_accepting;

  assign w_rx_accepting = (r_state == StIdle)   || (r_state == StGetAddr) ||
                          (r_state == StGetLen) || (r_state == StGetData);

  always_comb begin
    w_state_next    = r_state;
    w_is_write_next = r_is_write;
    w_count_next    = r_count;
    w_addr_next     = r_addr;
    w_wdata_next    = r_wdata;
    w_tx_byte_next  = r_tx_byte;
    w_err_next      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.rx_valid) begin
          if ((bus.rx_byte == CmdRead) || (bus.rx_byte == CmdWrite)) begin
            w_is_write_next = (bus.rx_byte == CmdWrite);
            w_state_next    = StGetAddr;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      StGetAddr: begin
        if (bus.rx_valid) begin
          w_addr_next  = bus.rx_byte;
          w_state_next = StGetLen;
        end
      end
      StGetLen: begin
        if (bus.rx_valid) begin
          // LEN of zero encodes a full 256-byte burst
          w_count_next = (bus.rx_byte == 8'h00) ? 9'd256 : {1'b0, bus.rx_byte};
          w_state_next = r_is_write ? StGetData : StRdReq;
        end
      end
      StGetData: begin
        if (bus.rx_valid) begin
          w_wdata_next = bus.rx_byte;
          w_state_next = StWr;
        end
      end
      StWr: begin
        w_addr_next  = r_addr + 8'd1;
        w_count_next = r_count - 9'd1;
        if (r_count == 9'd1) begin
          w_tx_byte_next = ACK_BYTE;
          w_state_next   = StSend;
        end else begin
          w_state_next = StGetData;
        end
      end
      StRdReq: w_state_next = StRdCap;
      StRdCap: begin
        w_tx_byte_next = bus.mem_read_byte;
        w_state_next   = StSend;
      end
      StSend:   w_state_next = StTxHold;
      // tx_busy may still be low here, so the hold state skips one sample
      StTxHold: w_state_next = StTxWait;
      StTxWait: begin
        if (!bus.tx_busy) begin
          if (r_is_write) begin
            w_state_next = StIdle;
          end else begin
            w_addr_next  = r_addr + 8'd1;
            w_count_next = r_count - 9'd1;
            w_state_next = (r_count == 9'd1) ? StIdle : StRdReq;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase

    if (bus.rx_valid && !w_rx_accepting) begin
      w_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_is_write  <= 1'b0;
      r_count     <= 9'd0;
      r_addr      <= 8'd0;
      r_wdata     <= 8'd0;
      r_tx_byte   <= 8'd0;
      r_err       <= 1'b0;
      r_tx_start  <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_is_write  <= w_is_write_next;
      r_count     <= w_count_next;
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
      r_tx_byte   <= w_tx_byte_next;
      r_err       <= w_err_next;
      // strobes are registered from the next state so they coincide with it
      r_tx_start  <= (w_state_next == StSend);
      r_mem_read  <= (w_state_next == StRdReq);
      r_mem_write <= (w_state_next == StWr);
      r_busy      <= (w_state_next != StIdle);
    end
  end

  assign bus.tx_start       = r_tx_start;
  assign bus.tx_byte        = r_tx_byte;
  assign bus.mem_read       = r_mem_read;
  assign bus.mem_write      = r_mem_write;
  assign bus.mem_addr       = r_addr;
  assign bus.mem_write_byte = r_wdata;
  assign o_busy             = r_busy;
  assign o_err              = r_err;

  a_no_rw_overlap : assert property (@(posedge clk) disable iff (!rst_n)
    !(r_mem_read && r_mem_write));
  a_strobe_state : assert property (@(posedge clk) disable iff (!rst_n)
    (r_mem_read -> (r_state == StRdReq)) && (r_mem_write -> (r_state == StWr)));

endmodule

// File: tb/tb_uart_mem_cmd.sv
// Scoreboard bench for uart_mem_cmd with a 256x8 memory model and a UART
// transmitter model of configurable busy length.
`timescale 1ns/1ps
module tb_uart_mem_cmd;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic err;

  uart_mem_cmd_if bus ();

  uart_mem_cmd #(.ACK_BYTE(8'h02)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .o_busy(busy),
    .o_err (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Memory model: unwritten locations read back as addr ^ 5A.
  bit [7:0] mem     [256];
  bit       written [256];
  int       tx_len = 2;
  int       tx_cnt = 0;
  assign bus.tx_busy = (tx_cnt != 0);

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_addr]     <= bus.mem_write_byte;
      written[bus.mem_addr] <= 1'b1;
    end
    if (bus.mem_read)
      bus.mem_read_byte <= written[bus.mem_addr] ? mem[bus.mem_addr] : (bus.mem_addr ^ 8'h5A);
    else
      bus.mem_read_byte <= 8'h00;
    if (bus.tx_start) tx_cnt <= tx_len;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t q_wr[$];
  exp_t q_rd[$];
  exp_t q_tx[$];
  logic [7:0] exp_mem [256];
  int tx_count = 0;
  int err_seen = 0;
  int err_exp  = 0;
  int overlap  = 0;
  int tx_exp_byte = 0;
  bit tx_track = 1'b0;
  bit tx_bad = 1'b0;
  bit tx_seen_busy = 1'b0;

  // Monitor: pops expectations whenever the DUT presents a strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mem_read && bus.mem_write) overlap++;
        if (err) err_seen++;
        if (bus.mem_write) begin
          if (q_wr.size() == 0) check("wr_unexpected", 1, 0);
          else begin
            e = q_wr.pop_front();
            check("wr_addr", int'(bus.mem_addr), e.addr);
            check("wr_data", int'(bus.mem_write_byte), e.data);
            if (e.cyc >= 0) check("wr_latency", cyc, e.cyc);
          end
        end
        if (bus.mem_read) begin
          if (q_rd.size() == 0) check("rd_unexpected", 1, 0);
          else begin
            e = q_rd.pop_front();
            check("rd_addr", int'(bus.mem_addr), e.addr);
            if (e.cyc >= 0) check("rd_latency", cyc, e.cyc);
          end
        end
        if (bus.tx_start) begin
          tx_count++;
          check("tx_start_while_busy", int'(bus.tx_busy), 0);
          if (q_tx.size() == 0) check("tx_unexpected", 1, 0);
          else begin
            e = q_tx.pop_front();
            check("tx_byte", int'(bus.tx_byte), e.data);
            if (e.cyc >= 0) check("tx_latency", cyc, e.cyc);
            tx_exp_byte  = e.data;
            tx_track     = 1'b1;
            tx_bad       = 1'b0;
            tx_seen_busy = 1'b0;
          end
        end else if (tx_track) begin
          if (int'(bus.tx_byte) != tx_exp_byte) tx_bad = 1'b1;
          if (bus.tx_busy) tx_seen_busy = 1'b1;
          else if (tx_seen_busy) begin
            check("tx_byte_stable", int'(tx_bad), 0);
            tx_track = 1'b0;
          end
        end
      end
    end
  end

  task automatic drive_rx(input logic [7:0] b, output int t);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    t = cyc;
  endtask

  task automatic end_rx();
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    drive_rx(b, t);
    end_rx();
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2);
    logic [7:0] d [3];
    logic [7:0] a;
    int t;
    d[0] = b0;
    d[1] = b1;
    d[2] = b2;
    send(8'h02);
    send(addr);
    send(8'h03);
    for (int i = 0; i < 3; i++) begin
      drive_rx(d[i], t);
      a = addr + 8'(i);
      q_wr.push_back('{int'(a), int'(d[i]), t + 1});
      exp_mem[a] = d[i];
      if (i == 2) q_tx.push_back('{0, 8'h02, t + 2});
      end_rx();
    end
  endtask

  // Sends a read frame; n is the burst length (256 encoded as LEN 00).
  task automatic start_read(input logic [7:0] addr, input int n);
    logic [7:0] a;
    int t;
    send(8'h01);
    send(addr);
    drive_rx(8'(n), t);
    for (int i = 0; i < n; i++) begin
      a = addr + 8'(i);
      q_rd.push_back('{int'(a), 0, (i == 0) ? t + 1 : -1});
      q_tx.push_back('{0, int'(exp_mem[a]), (i == 0) ? t + 3 : -1});
    end
    end_rx();
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while ((busy || bus.tx_busy || q_tx.size() != 0 || q_rd.size() != 0 || q_wr.size() != 0)
           && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("idle_within_budget", int'(k >= limit), 0);
  endtask

  task automatic wait_tx(input int n, input int limit);
    int k = 0;
    while (tx_count < n && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("tx_start_within_budget", int'(k >= limit), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_tx_start", int'(bus.tx_start), 0);
    check("rst_tx_byte", int'(bus.tx_byte), 0);
    check("rst_mem_read", int'(bus.mem_read), 0);
    check("rst_mem_write", int'(bus.mem_write), 0);
    check("rst_mem_addr", int'(bus.mem_addr), 0);
    check("rst_mem_write_byte", int'(bus.mem_write_byte), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write then read back with exact latencies
    do_write(8'h10, 8'hAA, 8'hBB, 8'hCC);
    wait_idle(500);
    start_read(8'h10, 3);
    wait_idle(500);

    // Address wrap FE, FF, 00
    do_write(8'hFE, 8'h11, 8'h22, 8'h33);
    wait_idle(500);
    start_read(8'hFE, 3);
    wait_idle(500);

    // Unknown command stays idle
    send(8'h7F);
    err_exp++;
    repeat (2) @(posedge clk);
    #1;
    check("err_unknown_cmd", err_seen, err_exp);
    check("idle_after_bad_cmd", int'(busy), 0);

    // Byte injected during TX_WAIT is dropped with err
    tx_len = 20;
    n = tx_count;
    start_read(8'h10, 3);
    wait_tx(n + 1, 200);
    repeat (6) @(posedge clk);
    send(8'h55);
    err_exp++;
    wait_idle(1000);
    check("err_in_tx_wait", err_seen, err_exp);

    // Slow transmitter
    tx_len = 50;
    start_read(8'hFE, 3);
    wait_idle(2000);

    // LEN 0 = 256 bytes over the full address range
    tx_len = 3;
    start_read(8'h00, 256);
    wait_idle(20000);
    check("idle_after_256", int'(busy), 0);

    // Reset mid-burst, then a normal frame
    tx_len = 10;
    n = tx_count;
    start_read(8'h00, 5);
    wait_tx(n + 2, 500);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    q_wr.delete();
    q_rd.delete();
    q_tx.delete();
    tx_track = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_idle(200);
    start_read(8'h10, 3);
    wait_idle(500);

    check("err_total", err_seen, err_exp);
    check("rw_overlap", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
